// File: rtl/main_fsm.sv
// main_fsm: multicycle main control FSM for the RV32I core.
// Sequences fetch/decode/execute/memory/writeback over the shared datapath,
// producing mux selects, ALUop and all architectural write enables.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap unrecognised opcodes in
// TRAP (illegal=1, sticky until reset); otherwise they act as a 2-cycle NOP.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t cur;
  state_t dec;

  assign state = cur;

  // State register: reset wins over every transition, including mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: cur <= S_MEMADR;
            OP_R:              cur <= S_EXECR;
            OP_I:              cur <= S_EXECI;
            OP_BR:             cur <= S_BRANCH;
            OP_JAL:            cur <= S_JAL;
            OP_JALR:           cur <= S_JALR;
            OP_LUI:            cur <= S_LUI;
            OP_AUIPC:          cur <= S_AUIPC;
`ifdef ILLEGAL_OP_TRAP_EN
            default:           cur <= S_TRAP;
`else
            default:           cur <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR:   cur <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWB:    cur <= S_FETCH;
        S_MEMWRITE: if (mem_ready) cur <= S_FETCH;
        S_EXECR:    cur <= S_ALUWB;
        S_EXECI:    cur <= S_ALUWB;
        S_ALUWB:    cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        S_JAL:      cur <= S_ALUWB;
        S_JALR:     cur <= S_LINK;
        S_LINK:     cur <= S_ALUWB;
        S_LUI:      cur <= S_ALUWB;
        S_AUIPC:    cur <= S_ALUWB;
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_FETCH;
      endcase
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = (cur == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  // Output decode; reset substitutes FETCH and masks every write enable so a
  // mid-instruction reset never lets a write through in its own cycle.
  always_comb begin
    dec       = reset ? S_FETCH : cur;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    ALUop     = '0;
    case (dec)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUop = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUop = 2'b10; end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH:   begin ALUSrcA = 2'b10; ALUop = 2'b01; Branch = 1'b1; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCUpdate = 1'b1; end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCUpdate  = 1'b1;
      end
      S_LINK:     begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
      S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      S_AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      default:    ;
    endcase
    if (reset) begin
      PCUpdate = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: scoreboard bench for main_fsm. Each cycle an expected
// {state, controls} word is pushed from a table of the documented per-state
// outputs and popped against the DUT at the falling edge.
// Honours ILLEGAL_OP_TRAP_EN the same way the design does.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUop;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  logic [18:0] sb[$];

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  main_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .Branch(Branch), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .RegWrite(RegWrite),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Expected word for a given state / mem_ready / reset, from the output table.
  function automatic logic [18:0] mk(input logic [3:0] st, input logic mr, input logic rst);
    logic pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sbs, op;
    logic [3:0] d;
    {pcu, br, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sbs, op} = '0;
    d = rst ? 4'd0 : st;
    case (d)
      4'd0:  begin sbs = 2'd2; rs = 2'd2; irw = mr; pcu = mr; end
      4'd1:  begin sa = 2'd1; sbs = 2'd1; end
      4'd2:  begin sa = 2'd2; sbs = 2'd1; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'd1; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 2'd2; op = 2'd2; end
      4'd7:  begin sa = 2'd2; sbs = 2'd1; op = 2'd2; end
      4'd8:  rw = 1'b1;
      4'd9:  begin sa = 2'd2; op = 2'd1; br = 1'b1; end
      4'd10: begin sa = 2'd1; sbs = 2'd2; pcu = 1'b1; end
      4'd11: begin sa = 2'd2; sbs = 2'd1; rs = 2'd2; pcu = 1'b1; end
      4'd12: begin sa = 2'd1; sbs = 2'd2; end
      4'd13: begin sa = 2'd3; sbs = 2'd1; end
      4'd14: begin sa = 2'd1; sbs = 2'd1; end
      default: ;
    endcase
    if (rst) {pcu, irw, mw, rw, br} = '0;
`ifdef ILLEGAL_OP_TRAP_EN
    ill = (st == 4'd15);
`endif
    return {st, pcu, br, adr, mw, irw, rs, sa, sbs, op, rw, ill};
  endfunction

  function automatic logic [18:0] obs();
    return {state, PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUop, RegWrite, illegal};
  endfunction

  // Apply inputs for one cycle just after the rising edge; return at the falling edge.
  task automatic drive(input logic r, input logic m, input logic [6:0] o);
    @(posedge clk);
    #1;
    reset = r;
    mem_ready = m;
    opcode = o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [18:0] got, want;
    logic [3:0] st [3] = '{4'd0, 4'd0, 4'd0};
    logic       mr [3] = '{1'b1, 1'b0, 1'b1};
    logic       rs [3] = '{1'b1, 1'b0, 1'b0};
    drive(1'b1, 1'b1, OP_R);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(st[i], mr[i], rs[i]));
      drive(rs[i], mr[i], 7'd0);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_add();
    logic [18:0] got, want;
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    drive(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(st[i], 1'b1, 1'b0));
      drive(1'b0, 1'b1, OP_R);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL add cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [18:0] got, want;
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(1'b1, 1'b0, OP_LOAD);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(st[i], mr[i], 1'b0));
      drive(1'b0, mr[i], OP_LOAD);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL lw cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [18:0] got, want;
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    logic       mr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 1'b0, OP_STORE);
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(st[i], mr[i], 1'b0));
      drive(1'b0, mr[i], OP_STORE);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL sw cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_jalr();
    logic [18:0] got, want;
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd11, 4'd12, 4'd8, 4'd0};
    drive(1'b1, 1'b0, OP_JALR);
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(st[i], 1'b1, 1'b0));
      drive(1'b0, 1'b1, OP_JALR);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL jalr cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] got, want;
    logic [3:0] st [21] = '{4'd0, 4'd0, 4'd1, 4'd9,
                            4'd0, 4'd1, 4'd10, 4'd8,
                            4'd0, 4'd1, 4'd13, 4'd8,
                            4'd0, 4'd1, 4'd14, 4'd8,
                            4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    logic [6:0] op [21] = '{OP_BR, OP_BR, OP_BR, OP_BR,
                            OP_JAL, OP_JAL, OP_JAL, OP_JAL,
                            OP_LUI, OP_LUI, OP_LUI, OP_LUI,
                            OP_AUIPC, OP_AUIPC, OP_AUIPC, OP_AUIPC,
                            OP_I, OP_I, OP_I, OP_I, OP_I};
    logic       mr;
    drive(1'b1, 1'b0, OP_BR);
    for (int i = 0; i < 21; i++) begin
      mr = !(i == 0 || i == 20);
      sb.push_back(mk(st[i], mr, 1'b0));
      drive(1'b0, mr, op[i]);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] got, want;
    logic [3:0]  st_q[$];
    logic        rs_q[$];
    st_q.push_back(4'd0); rs_q.push_back(1'b0);
    st_q.push_back(4'd1); rs_q.push_back(1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      st_q.push_back(4'd15); rs_q.push_back(1'b0);
    end
    st_q.push_back(4'd15); rs_q.push_back(1'b1);
`endif
    st_q.push_back(4'd0); rs_q.push_back(1'b0);
    drive(1'b1, 1'b0, 7'd0);
    for (int i = 0; i < st_q.size(); i++) begin
      sb.push_back(mk(st_q[i], 1'b1, rs_q[i]));
      drive(rs_q[i], 1'b1, 7'd0);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL illegal cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [18:0] got, want;
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic       mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       rs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 1'b0, OP_STORE);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(st[i], mr[i], rs[i]));
      drive(rs[i], mr[i], OP_STORE);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rst_mid cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_wait();
    test_jalr();
    test_back_to_back();
    test_illegal();
    test_reset_mid_write();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle main control state machine for the RV32I core. It sequences the shared datapath (register file, ALU, instruction/data memory port, PC, ALUOut) one instruction at a time, from fetch through writeback. It drives the 2-bit ALUop consumed by the ALU decoder, the operand/result mux selects and all architectural write enables. It sits beside the ALU decoder in the control unit and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; forces state to FETCH.
- opcode  input  7  instr[6:0] from the instruction register; sampled only in DECODE.
- mem_ready  input  1  memory port completes the current access this cycle.
- PCUpdate  output  1  PC write enable (branch-taken gating is external).
- Branch  output  1  branch-compare cycle; external logic writes PC when the compare is true.
- AdrSrc  output  1  0 = PC, 1 = Result drives the memory address.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  load instruction register and OldPC.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- ALUSrcB  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUop  output  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- RegWrite  output  1  register file write enable.
- illegal  output  1  sticky illegal-opcode flag (see Configuration).
- state  output  4  current state encoding, for debug.

## Operation
- State encodings 0–15: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, AUIPC, TRAP.
- Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUop=00, ResultSrc=10; IRWrite = PCUpdate = mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUop=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH
  - 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC
  - otherwise → TRAP or FETCH (Configuration).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUop=00. Goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready. Then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUop=10. Then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUop=10. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUop=01, ResultSrc=00, Branch=1. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUop=00, ResultSrc=00, PCUpdate=1. PC takes the target; ALUOut takes OldPC+4. Then ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUop=00, ResultSrc=10, PCUpdate=1. Then LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, ALUop=00. Then ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUop=00. Then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUop=00. Then ALUWB.

## Timing
- Reset, sampled at a rising edge, sets state=FETCH and clears illegal. It overrides every transition, including a mem_ready arriving in the same cycle.
- While reset is high, PCUpdate, IRWrite, MemWrite, RegWrite and Branch are forced to 0. All other outputs follow FETCH decode.
- Reset asserted mid-instruction (e.g. in MEMWRITE) drops MemWrite in the same cycle. No partial writeback occurs.
- All outputs except IRWrite and PCUpdate in FETCH are Moore (functions of state only).
- With mem_ready held high, cycles per instruction:
  - lw 5; sw 4
  - R-type, I-type, jal, lui, auipc 4
  - branch 3; jalr 5
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while waiting.
- mem_ready is ignored in every other state.

## Configuration
- ILLEGAL_OP_TRAP_EN defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP asserts illegal=1 with all write enables 0 and stays there until reset.
- ILLEGAL_OP_TRAP_EN undefined:
  - An unrecognised opcode goes from DECODE to FETCH, so the instruction acts as a 2-cycle NOP.
  - The TRAP encoding (15) is unreachable and illegal is tied to 0.

## Test plan
- Reset then add (opcode 0110011), mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB, FETCH. ALUop=10 in EXECR; RegWrite=1 only in ALUWB.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; AdrSrc=1 throughout the wait; RegWrite with ResultSrc=01 in MEMWB.
- sw (0100011) with mem_ready low 1 cycle → MemWrite high for 2 consecutive cycles, then FETCH; RegWrite never asserted.
- jalr (1100111) → PCUpdate=1 with ResultSrc=10 in JALR; LINK has ALUSrcA=01 and ALUSrcB=10; RegWrite in ALUWB; 5 cycles.
- Opcode 0000000 → with ILLEGAL_OP_TRAP_EN: state=15 and illegal=1, held for 20 cycles until reset clears it. Without the macro: back in FETCH after DECODE, illegal=0.
- Reset asserted in MEMWRITE with mem_ready=1 → next state FETCH; MemWrite=0 during the reset cycle.
